// File: rtl/voronoi_pkg.sv
// ============================================================================
// Module      : voronoi_pkg
// Description : Shared types and default constants for the Voronoi lactone
//               field and band-detector stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package voronoi_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } colour_t;

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_STABLE = 1'b1
    } settle_state_t;

    localparam int LVL_W_DEFAULT         = 8;
    localparam int STEP_DEFAULT          = 4;
    localparam int LAC_LO_DEFAULT        = 16;
    localparam int LAC_HI_DEFAULT        = 48;
    localparam int DECAY_PERIOD_DEFAULT  = 8;
    localparam int SETTLE_CYCLES_DEFAULT = 16;

    // Counter width that stays legal for ranges of one or fewer values
    function automatic int width_for(input int n_values);
        return (n_values <= 1) ? 1 : $clog2(n_values);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lac_accumulator_if.sv
// ============================================================================
// Module      : lac_accumulator_if
// Description : Source/clear controls and threshold/level observation bus of
//               the lactone accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lac_accumulator_if #(
    parameter int LVL_W = voronoi_pkg::LVL_W_DEFAULT
);
    logic             freeze;
    logic             srcRed;
    logic             srcGreen;
    logic             srcYellow;
    logic             clrRed;
    logic             clrGreen;
    logic             clrYellow;
    logic             lacMRed;
    logic             lacRed;
    logic             lacMGreen;
    logic             lacGreen;
    logic             lacMYellow;
    logic             lacYellow;
    logic [LVL_W-1:0] levelRed;
    logic [LVL_W-1:0] levelGreen;
    logic [LVL_W-1:0] levelYellow;
    logic             stable;

    modport master (
        output freeze, srcRed, srcGreen, srcYellow, clrRed, clrGreen, clrYellow,
        input  lacMRed, lacRed, lacMGreen, lacGreen, lacMYellow, lacYellow,
        input  levelRed, levelGreen, levelYellow, stable
    );

    modport slave (
        input  freeze, srcRed, srcGreen, srcYellow, clrRed, clrGreen, clrYellow,
        output lacMRed, lacRed, lacMGreen, lacGreen, lacMYellow, lacYellow,
        output levelRed, levelGreen, levelYellow, stable
    );
endinterface

`default_nettype wire

// File: rtl/lac_channel.sv
// ============================================================================
// Module      : lac_channel
// Description : One colour's saturating lactone level with decay and the
//               lacM/lac threshold decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lac_channel #(
    parameter int LVL_W  = voronoi_pkg::LVL_W_DEFAULT,
    parameter int STEP   = voronoi_pkg::STEP_DEFAULT,
    parameter int LAC_LO = voronoi_pkg::LAC_LO_DEFAULT,
    parameter int LAC_HI = voronoi_pkg::LAC_HI_DEFAULT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             freeze_i,
    input  wire logic             tick_i,
    input  wire logic             src_i,
    input  wire logic             clr_i,
    output logic [LVL_W-1:0]      level_o,
    output logic                  changed_o,
    output logic                  lacm_o,
    output logic                  lac_o
);
    localparam int SUM_W = LVL_W + 1;

    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [SUM_W-1:0] w_sum;
    logic             w_dec;

    // One spare bit catches overflow; decay only fires on a non-zero level,
    // so the subtraction can never underflow.
    always_comb begin
        w_dec = tick_i && (level_q != '0);
        w_sum = {1'b0, level_q} + (src_i ? SUM_W'(STEP) : '0) - SUM_W'(w_dec);
        if (clr_i) begin
            level_d = '0;
        end else if (freeze_i) begin
            level_d = level_q;
        end else if (w_sum[LVL_W]) begin
            level_d = '1;
        end else begin
            level_d = w_sum[LVL_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o   = level_q;
    assign changed_o = (level_d != level_q);
    assign lacm_o    = (level_q < LVL_W'(LAC_LO));
    assign lac_o     = (level_q >= LVL_W'(LAC_HI));

endmodule

`default_nettype wire

// File: rtl/lac_accumulator.sv
// ============================================================================
// Module      : lac_accumulator
// Description : Three-colour lactone field integrator with shared decay
//               prescaler and a settle detector for leader selection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lac_accumulator
    import voronoi_pkg::*;
#(
    parameter int LVL_W         = LVL_W_DEFAULT,
    parameter int STEP          = STEP_DEFAULT,
    parameter int LAC_LO        = LAC_LO_DEFAULT,
    parameter int LAC_HI        = LAC_HI_DEFAULT,
    parameter int DECAY_PERIOD  = DECAY_PERIOD_DEFAULT,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    lac_accumulator_if.slave bus
);
    localparam int PRE_W = width_for(DECAY_PERIOD);
    localparam int CNT_W = width_for(SETTLE_CYCLES + 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [CNT_W-1:0] settle_cnt_q;
    settle_state_t    state_q;
    logic             w_tick;
    logic             w_chg_r;
    logic             w_chg_g;
    logic             w_chg_y;
    logic             w_changed;

    assign w_tick = (pre_q == PRE_W'(DECAY_PERIOD - 1));

    always_comb begin
        if (bus.freeze) begin
            pre_d = pre_q;
        end else if (w_tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    lac_channel #(.LVL_W(LVL_W), .STEP(STEP), .LAC_LO(LAC_LO), .LAC_HI(LAC_HI)) u_red (
        .clk(clk), .rst(rst), .freeze_i(bus.freeze), .tick_i(w_tick),
        .src_i(bus.srcRed), .clr_i(bus.clrRed), .level_o(bus.levelRed),
        .changed_o(w_chg_r), .lacm_o(bus.lacMRed), .lac_o(bus.lacRed)
    );

    lac_channel #(.LVL_W(LVL_W), .STEP(STEP), .LAC_LO(LAC_LO), .LAC_HI(LAC_HI)) u_green (
        .clk(clk), .rst(rst), .freeze_i(bus.freeze), .tick_i(w_tick),
        .src_i(bus.srcGreen), .clr_i(bus.clrGreen), .level_o(bus.levelGreen),
        .changed_o(w_chg_g), .lacm_o(bus.lacMGreen), .lac_o(bus.lacGreen)
    );

    lac_channel #(.LVL_W(LVL_W), .STEP(STEP), .LAC_LO(LAC_LO), .LAC_HI(LAC_HI)) u_yellow (
        .clk(clk), .rst(rst), .freeze_i(bus.freeze), .tick_i(w_tick),
        .src_i(bus.srcYellow), .clr_i(bus.clrYellow), .level_o(bus.levelYellow),
        .changed_o(w_chg_y), .lacm_o(bus.lacMYellow), .lac_o(bus.lacYellow)
    );

    assign w_changed = w_chg_r | w_chg_g | w_chg_y;

    // A clear during freeze still counts as activity and restarts settling
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            settle_cnt_q <= '0;
        end else if (w_changed) begin
            state_q      <= S_RUN;
            settle_cnt_q <= '0;
        end else if (!bus.freeze) begin
            case (state_q)
                S_RUN: begin
                    if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_q      <= S_STABLE;
                        settle_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_STABLE;
                end
            endcase
        end
    end

    assign bus.stable = (state_q == S_STABLE);

endmodule

`default_nettype wire
